// File: rtl/mvm_job_ctrl_pkg.sv
// Shared constants and state encoding for the matrix-vector job controller.
// Imported by the controller, its unpacker and the bench.
package mvm_pkg;

    localparam int N          = 8;
    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 24;
    localparam int WORD_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        RSTM,
        RDREQ,
        RDWAIT,
        UNPK,
        WAITD,
        WR,
        FIN
    } job_state_t;

endpackage

// File: rtl/mvm_job_ctrl_if.sv
// Single-outstanding read and write memory port used by the job controller.
// The controller drives the master side, the memory/bus the slave side.
interface mvm_job_ctrl_if;

    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic        wr_gnt;

    modport master (
        output rd_req, rd_addr,
        input  rd_gnt, rd_valid, rd_data,
        output wr_req, wr_addr, wr_data,
        input  wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr,
        output rd_gnt, rd_valid, rd_data,
        input  wr_req, wr_addr, wr_data,
        output wr_gnt
    );

endinterface

// File: rtl/mvm_job_ctrl_unpacker.sv
// Holds one 64-bit memory word and walks through its bytes, LSB first.
// The byte index only moves on an advance that is not stalled.
module word_unpacker
    import mvm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_BYTES*8-1:0] load_data,
    input  logic                  advance,
    input  logic                  stall,
    output logic [7:0]            byte_out,
    output logic                  last
);

    localparam int BIW = $clog2(WORD_BYTES);

    logic [WORD_BYTES*8-1:0] word_q, word_d;
    logic [BIW-1:0]          byte_idx_q, byte_idx_d;

    always_comb begin
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        if (load) begin
            word_d     = load_data;
            byte_idx_d = '0;
        end else if (advance && !stall) begin
            byte_idx_d = byte_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= '0;
            byte_idx_q <= '0;
        end else begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign byte_out = word_q[{byte_idx_q, 3'b000} +: 8];
    assign last     = (byte_idx_q == BIW'(WORD_BYTES - 1));

endmodule

// File: rtl/mvm_job_ctrl.sv
// Job controller: resets the multiplier, streams A rows and B from memory
// into its FIFOs byte by byte, then writes the N results back.
module mvm_job_ctrl #(
    parameter int N          = mvm_pkg::N,
    parameter int DATA_WIDTH = mvm_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = mvm_pkg::ACC_WIDTH
) (
    input  logic                      CLOCK_50,
    input  logic                      rst,
    input  logic                      start,
    input  logic [31:0]               src_addr,
    input  logic [31:0]               dst_addr,
    output logic                      busy,
    output logic                      job_done,
    mvm_job_ctrl_if.master            mem,
    output logic                      mvm_rst_n,
    output logic [N-1:0]              a_wren,
    output logic [N*DATA_WIDTH-1:0]   a_data,
    output logic                      b_wren,
    output logic [DATA_WIDTH-1:0]     b_data,
    input  logic [N-1:0]              a_full,
    input  logic                      b_full,
    input  logic                      mvm_done,
    input  logic [N*ACC_WIDTH-1:0]    C_matrix
);

    import mvm_pkg::*;

    localparam int WIW = $clog2(N + 1);
    localparam int RIW = $clog2(N);

    job_state_t state_q, state_d;
    logic [31:0] src_q, src_d, dst_q, dst_d;
    logic [WIW-1:0] word_idx_q, word_idx_d;
    logic [RIW-1:0] res_idx_q, res_idx_d;
    logic [N-1:0] a_wren_q, a_wren_d;
    logic [N*DATA_WIDTH-1:0] a_data_q, a_data_d;
    logic b_wren_q, b_wren_d;
    logic [DATA_WIDTH-1:0] b_data_q, b_data_d;

    logic [7:0]           byte_out;
    logic                 last;
    logic                 is_b;
    logic [RIW-1:0]       row;
    logic                 tgt_full;
    logic [ACC_WIDTH-1:0] c_sel;

    // word N is the B vector; words 0..N-1 are the A rows
    assign is_b     = (word_idx_q == WIW'(N));
    assign row      = word_idx_q[RIW-1:0];
    assign tgt_full = is_b ? b_full : a_full[row];
    assign c_sel    = C_matrix[res_idx_q*ACC_WIDTH +: ACC_WIDTH];

    word_unpacker u_unpk (
        .clk       (CLOCK_50),
        .rst       (rst),
        .load      (state_q == RDWAIT && mem.rd_valid),
        .load_data (mem.rd_data),
        .advance   (state_q == UNPK),
        .stall     (tgt_full),
        .byte_out  (byte_out),
        .last      (last)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        word_idx_d  = word_idx_q;
        res_idx_d   = res_idx_q;
        a_wren_d    = '0;
        a_data_d    = a_data_q;
        b_wren_d    = 1'b0;
        b_data_d    = b_data_q;
        mem.rd_req  = 1'b0;
        mem.rd_addr = '0;
        mem.wr_req  = 1'b0;
        mem.wr_addr = '0;
        mem.wr_data = '0;
        job_done    = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                src_d      = src_addr;
                dst_d      = dst_addr;
                word_idx_d = '0;
                res_idx_d  = '0;
                state_d    = RSTM;
            end
            RSTM: state_d = RDREQ;
            RDREQ: begin
                mem.rd_req  = 1'b1;
                mem.rd_addr = src_q + (32'(word_idx_q) << 3);
                if (mem.rd_gnt) state_d = RDWAIT;
            end
            RDWAIT: if (mem.rd_valid) state_d = UNPK;
            UNPK: if (!tgt_full) begin
                if (is_b) begin
                    b_wren_d = 1'b1;
                    b_data_d = byte_out;
                end else begin
                    a_wren_d[row] = 1'b1;
                    a_data_d[row*DATA_WIDTH +: DATA_WIDTH] = byte_out;
                end
                if (last) begin
                    if (is_b) begin
                        state_d = WAITD;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = RDREQ;
                    end
                end
            end
            WAITD: if (mvm_done) begin
                res_idx_d = '0;
                state_d   = WR;
            end
            WR: begin
                mem.wr_req  = 1'b1;
                mem.wr_addr = dst_q + (32'(res_idx_q) << 3);
                mem.wr_data = 64'(c_sel);
                if (mem.wr_gnt) begin
                    res_idx_d = res_idx_q + 1'b1;
                    if (res_idx_q == RIW'(N - 1)) state_d = FIN;
                end
            end
            FIN: begin
                job_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            word_idx_q <= '0;
            res_idx_q  <= '0;
            a_wren_q   <= '0;
            a_data_q   <= '0;
            b_wren_q   <= 1'b0;
            b_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            word_idx_q <= word_idx_d;
            res_idx_q  <= res_idx_d;
            a_wren_q   <= a_wren_d;
            a_data_q   <= a_data_d;
            b_wren_q   <= b_wren_d;
            b_data_q   <= b_data_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign mvm_rst_n = !(rst || state_q == RSTM);
    assign a_wren    = a_wren_q;
    assign a_data    = a_data_q;
    assign b_wren    = b_wren_q;
    assign b_data    = b_data_q;

endmodule

// File: tb/tb_mvm_job_ctrl.sv
// Directed bench for mvm_job_ctrl with a memory responder and a
// behavioural multiplier that collects FIFO writes and computes C.
module tb_mvm_job_ctrl;

    import mvm_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic busy, job_done, mvm_rst_n, b_wren;
    logic [N-1:0] a_wren;
    logic [N-1:0] a_full = '0;
    logic [N*DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] b_data;
    logic b_full = 1'b0;
    logic mvm_done;
    logic [N*ACC_WIDTH-1:0] C_matrix;

    mvm_job_ctrl_if m ();

    mvm_job_ctrl dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .busy      (busy),
        .job_done  (job_done),
        .mem       (m),
        .mvm_rst_n (mvm_rst_n),
        .a_wren    (a_wren),
        .a_data    (a_data),
        .b_wren    (b_wren),
        .b_data    (b_data),
        .a_full    (a_full),
        .b_full    (b_full),
        .mvm_done  (mvm_done),
        .C_matrix  (C_matrix)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    bit rand_dly = 1'b0;
    int mvm_t = 3;
    logic [63:0] mem_rd [logic [31:0]];
    logic [63:0] mem_wr [logic [31:0]];
    logic [7:0] ma [N][N];
    logic [7:0] mb [N];
    int acnt [N];
    int bcnt;

    // read side: one request at a time, optional grant/valid wait states
    initial begin : rd_resp
        logic [31:0] a;
        int d;
        m.rd_gnt = 1'b0;
        m.rd_valid = 1'b0;
        m.rd_data = '0;
        @(negedge CLOCK_50);
        forever begin
            if (m.rd_req && !rst) begin
                a = m.rd_addr;
                d = rand_dly ? int'($urandom_range(0, 5)) : 0;
                repeat (d) begin
                    @(negedge CLOCK_50);
                    n_cmp++;
                    if (m.rd_req !== 1'b1 || m.rd_addr !== a) begin
                        n_err++;
                        $display("FAIL rd_hold: req=%b addr=%h, required req=1 addr=%h",
                                 m.rd_req, m.rd_addr, a);
                    end
                end
                m.rd_gnt = 1'b1;
                rd_cnt++;
                @(negedge CLOCK_50);
                m.rd_gnt = 1'b0;
                d = rand_dly ? int'($urandom_range(1, 5)) : 1;
                repeat (d - 1) begin
                    n_cmp++;
                    if (m.rd_req !== 1'b0) begin
                        n_err++;
                        $display("FAIL rd_outstanding: rd_req=%b, required 0", m.rd_req);
                    end
                    @(negedge CLOCK_50);
                end
                m.rd_valid = 1'b1;
                m.rd_data = mem_rd.exists(a) ? mem_rd[a] : 64'h0;
                @(negedge CLOCK_50);
                m.rd_valid = 1'b0;
                m.rd_data = '0;
            end else begin
                @(negedge CLOCK_50);
            end
        end
    end

    initial begin : wr_resp
        logic [31:0] a;
        logic [63:0] v;
        int d;
        m.wr_gnt = 1'b0;
        @(negedge CLOCK_50);
        forever begin
            if (m.wr_req && !rst) begin
                a = m.wr_addr;
                v = m.wr_data;
                d = rand_dly ? int'($urandom_range(0, 5)) : 0;
                repeat (d) begin
                    @(negedge CLOCK_50);
                    n_cmp++;
                    if (m.wr_req !== 1'b1 || m.wr_addr !== a || m.wr_data !== v) begin
                        n_err++;
                        $display("FAIL wr_hold: req=%b addr=%h data=%h, required 1 %h %h",
                                 m.wr_req, m.wr_addr, m.wr_data, a, v);
                    end
                end
                m.wr_gnt = 1'b1;
                mem_wr[a] = v;
                wr_cnt++;
                @(negedge CLOCK_50);
                m.wr_gnt = 1'b0;
            end else begin
                @(negedge CLOCK_50);
            end
        end
    end

    // multiplier stand-in: done mvm_t+1 cycles after the last FIFO write lands
    initial begin : mvm_model
        int dly;
        int tot;
        logic [23:0] acc;
        mvm_done = 1'b0;
        C_matrix = '0;
        dly = 0;
        bcnt = 0;
        foreach (acnt[r]) acnt[r] = 0;
        forever begin
            @(negedge CLOCK_50);
            if (!mvm_rst_n) begin
                foreach (acnt[r]) acnt[r] = 0;
                bcnt = 0;
                dly = 0;
                mvm_done = 1'b0;
                C_matrix = '0;
            end else begin
                for (int r = 0; r < N; r++) begin
                    if (a_wren[r]) begin
                        if (acnt[r] < N) ma[r][acnt[r]] = a_data[r*8 +: 8];
                        acnt[r]++;
                    end
                end
                if (b_wren) begin
                    if (bcnt < N) mb[bcnt] = b_data;
                    bcnt++;
                end
                tot = bcnt;
                foreach (acnt[r]) tot += acnt[r];
                if (!mvm_done && tot == N * N + N) begin
                    if (dly == mvm_t) begin
                        for (int i = 0; i < N; i++) begin
                            acc = '0;
                            for (int j = 0; j < N; j++)
                                acc = acc + 24'(ma[i][j]) * 24'(mb[j]);
                            C_matrix[i*ACC_WIDTH +: ACC_WIDTH] = acc;
                        end
                        mvm_done = 1'b1;
                    end else begin
                        dly++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic load_identity(input logic [31:0] s);
        mem_rd.delete();
        for (int r = 0; r < N; r++)
            mem_rd[s + 32'(8 * r)] = 64'h1 << (8 * r);
        mem_rd[s + 32'd64] = 64'h0807_0605_0403_0201;
    endtask

    // start a job at a negedge and wait (bounded) for job_done
    task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                           output int cyc, output int pulses);
        mem_wr.delete();
        rd_cnt = 0;
        wr_cnt = 0;
        src_addr = s;
        dst_addr = d;
        start = 1'b1;
        cyc = 0;
        pulses = 0;
        while (pulses == 0 && cyc < 3000) begin
            @(negedge CLOCK_50);
            if (cyc == 0) start = 1'b0;
            cyc++;
            if (job_done === 1'b1) pulses++;
        end
        repeat (6) begin
            @(negedge CLOCK_50);
            if (job_done === 1'b1) pulses++;
        end
        n_cmp++;
        if (cyc >= 3000) begin
            n_err++;
            $display("FAIL job_timeout: no job_done after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        n_cmp++;
        if ({busy, job_done, m.rd_req, m.wr_req, b_wren} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: busy/done/rdreq/wrreq/bwren=%b, required 00000",
                     {busy, job_done, m.rd_req, m.wr_req, b_wren});
        end
        n_cmp++;
        if (a_wren !== 8'h00) begin
            n_err++;
            $display("FAIL reset_a_wren: %h, required 00", a_wren);
        end
        n_cmp++;
        if (m.rd_addr !== 32'h0 || m.wr_addr !== 32'h0 || m.wr_data !== 64'h0) begin
            n_err++;
            $display("FAIL reset_bus: rd_addr=%h wr_addr=%h wr_data=%h, required 0",
                     m.rd_addr, m.wr_addr, m.wr_data);
        end
        n_cmp++;
        if (a_data !== 64'h0 || b_data !== 8'h0) begin
            n_err++;
            $display("FAIL reset_fifo_data: a=%h b=%h, required 0", a_data, b_data);
        end
        n_cmp++;
        if (mvm_rst_n !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mvm_rst_n: %b, required 0", mvm_rst_n);
        end
        rst = 1'b0;
        @(negedge CLOCK_50);
        n_cmp++;
        if (mvm_rst_n !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: mvm_rst_n=%b busy=%b, required 1 0", mvm_rst_n, busy);
        end
    endtask

    task automatic test_identity();
        int cyc, pulses;
        logic [31:0] d = 32'h0000_2000;
        rand_dly = 1'b0;
        mvm_t = 3;
        load_identity(32'h0000_1000);
        run_job(32'h0000_1000, d, cyc, pulses);
        n_cmp++;
        if (cyc !== 104) begin
            n_err++;
            $display("FAIL ident_latency: %0d cycles, required 104", cyc);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL ident_done_pulses: %0d, required 1", pulses);
        end
        n_cmp++;
        if (rd_cnt !== 9 || wr_cnt !== 8) begin
            n_err++;
            $display("FAIL ident_txn_count: rd=%0d wr=%0d, required 9 8", rd_cnt, wr_cnt);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (!mem_wr.exists(d + 32'(8 * i)) || mem_wr[d + 32'(8 * i)] !== 64'(i + 1)) begin
                n_err++;
                $display("FAIL ident_result[%0d]: addr %h not %0d", i, d + 32'(8 * i), i + 1);
            end
        end
    endtask

    // source and destination both straddle the 2^32 wrap
    task automatic test_full_scale();
        int cyc, pulses;
        logic [31:0] s = 32'hFFFF_FFE0;
        logic [31:0] d = 32'hFFFF_FFF0;
        mem_rd.delete();
        for (int k = 0; k <= N; k++) mem_rd[s + 32'(8 * k)] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_job(s, d, cyc, pulses);
        n_cmp++;
        if (rd_cnt !== 9 || wr_cnt !== 8) begin
            n_err++;
            $display("FAIL full_txn_count: rd=%0d wr=%0d, required 9 8", rd_cnt, wr_cnt);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (!mem_wr.exists(d + 32'(8 * i)) || mem_wr[d + 32'(8 * i)] !== 64'h7F008) begin
                n_err++;
                $display("FAIL full_result[%0d]: addr %h not 7f008", i, d + 32'(8 * i));
            end
        end
    endtask

    task automatic test_wait_states();
        int cyc, pulses;
        logic [31:0] d = 32'h0000_5008;
        rand_dly = 1'b1;
        load_identity(32'h0000_4000);
        run_job(32'h0000_4000, d, cyc, pulses);
        rand_dly = 1'b0;
        n_cmp++;
        if (rd_cnt !== 9 || wr_cnt !== 8 || pulses !== 1) begin
            n_err++;
            $display("FAIL wait_txn_count: rd=%0d wr=%0d done=%0d, required 9 8 1",
                     rd_cnt, wr_cnt, pulses);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (!mem_wr.exists(d + 32'(8 * i)) || mem_wr[d + 32'(8 * i)] !== 64'(i + 1)) begin
                n_err++;
                $display("FAIL wait_result[%0d]: addr %h not %0d", i, d + 32'(8 * i), i + 1);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cyc, pulses;
        logic [31:0] d = 32'h0000_7000;
        load_identity(32'h0000_6000);
        fork
            run_job(32'h0000_6000, d, cyc, pulses);
            begin
                repeat (5) @(negedge CLOCK_50);
                start = 1'b1;
                @(negedge CLOCK_50);
                start = 1'b0;
            end
        join
        n_cmp++;
        if (cyc !== 104 || pulses !== 1) begin
            n_err++;
            $display("FAIL busy_start_timing: cyc=%0d pulses=%0d, required 104 1", cyc, pulses);
        end
        n_cmp++;
        if (rd_cnt !== 9 || wr_cnt !== 8) begin
            n_err++;
            $display("FAIL busy_start_txn: rd=%0d wr=%0d, required 9 8", rd_cnt, wr_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_start_idle: busy=%b, required 0", busy);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (!mem_wr.exists(d + 32'(8 * i)) || mem_wr[d + 32'(8 * i)] !== 64'(i + 1)) begin
                n_err++;
                $display("FAIL busy_result[%0d]: addr %h not %0d", i, d + 32'(8 * i), i + 1);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int cyc, pulses, k;
        logic [31:0] d = 32'h0000_9000;
        mvm_t = 30;
        load_identity(32'h0000_8000);
        mem_wr.delete();
        wr_cnt = 0;
        src_addr = 32'h0000_8000;
        dst_addr = d;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        k = 0;
        while (b_wren !== 1'b1 && k < 2000) begin
            @(negedge CLOCK_50);
            k++;
        end
        repeat (5) @(negedge CLOCK_50);
        n_cmp++;
        if (busy !== 1'b1 || mvm_done !== 1'b0 || k >= 2000) begin
            n_err++;
            $display("FAIL mid_in_waitd: busy=%b mvm_done=%b wait=%0d, required 1 0 <2000",
                     busy, mvm_done, k);
        end
        rst = 1'b1;
        @(negedge CLOCK_50);
        n_cmp++;
        if ({busy, job_done, m.rd_req, m.wr_req, b_wren, mvm_rst_n} !== 6'b0) begin
            n_err++;
            $display("FAIL mid_reset_ctrl: %b, required 000000",
                     {busy, job_done, m.rd_req, m.wr_req, b_wren, mvm_rst_n});
        end
        n_cmp++;
        if (a_wren !== 8'h0 || a_data !== 64'h0 || b_data !== 8'h0) begin
            n_err++;
            $display("FAIL mid_reset_fifo: wren=%h a=%h b=%h, required 0", a_wren, a_data, b_data);
        end
        n_cmp++;
        if (m.rd_addr !== 32'h0 || m.wr_addr !== 32'h0 || m.wr_data !== 64'h0) begin
            n_err++;
            $display("FAIL mid_reset_bus: %h %h %h, required 0", m.rd_addr, m.wr_addr, m.wr_data);
        end
        n_cmp++;
        if (wr_cnt !== 0) begin
            n_err++;
            $display("FAIL mid_reset_writes: %0d, required 0", wr_cnt);
        end
        rst = 1'b0;
        mvm_t = 3;
        @(negedge CLOCK_50);
        run_job(32'h0000_8000, d, cyc, pulses);
        n_cmp++;
        if (cyc !== 104 || rd_cnt !== 9 || wr_cnt !== 8) begin
            n_err++;
            $display("FAIL mid_rerun: cyc=%0d rd=%0d wr=%0d, required 104 9 8", cyc, rd_cnt, wr_cnt);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (!mem_wr.exists(d + 32'(8 * i)) || mem_wr[d + 32'(8 * i)] !== 64'(i + 1)) begin
                n_err++;
                $display("FAIL mid_result[%0d]: addr %h not %0d", i, d + 32'(8 * i), i + 1);
            end
        end
    endtask

    // row 3 = 1..8, so C[3] = 1+4+9+...+64 = 204
    task automatic test_full_stall();
        int cyc, pulses, k;
        logic [31:0] s = 32'h0000_A000;
        logic [31:0] d = 32'h0000_B000;
        logic [63:0] exp_c [N];
        load_identity(s);
        mem_rd[s + 32'd24] = 64'h0807_0605_0403_0201;
        for (int i = 0; i < N; i++) exp_c[i] = 64'(i + 1);
        exp_c[3] = 64'd204;
        fork
            run_job(s, d, cyc, pulses);
            begin
                k = 0;
                @(negedge CLOCK_50);
                while (a_wren[3] !== 1'b1 && k < 2000) begin
                    @(negedge CLOCK_50);
                    k++;
                end
                n_cmp++;
                if (a_data[24 +: 8] !== 8'h01 || k >= 2000) begin
                    n_err++;
                    $display("FAIL stall_byte0: data=%h wait=%0d, required 01 <2000",
                             a_data[24 +: 8], k);
                end
                a_full[3] = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(negedge CLOCK_50);
                    n_cmp++;
                    if (a_wren[3] !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_no_write[%0d]: a_wren[3]=%b, required 0", j, a_wren[3]);
                    end
                end
                a_full[3] = 1'b0;
                @(negedge CLOCK_50);
                n_cmp++;
                if (a_wren[3] !== 1'b1 || a_data[24 +: 8] !== 8'h02) begin
                    n_err++;
                    $display("FAIL stall_resend: wren=%b data=%h, required 1 02",
                             a_wren[3], a_data[24 +: 8]);
                end
            end
        join
        n_cmp++;
        if (acnt[3] !== 8 || pulses !== 1) begin
            n_err++;
            $display("FAIL stall_row3_writes: %0d writes %0d done, required 8 1", acnt[3], pulses);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (!mem_wr.exists(d + 32'(8 * i)) || mem_wr[d + 32'(8 * i)] !== exp_c[i]) begin
                n_err++;
                $display("FAIL stall_result[%0d]: addr %h not %0d", i, d + 32'(8 * i), exp_c[i]);
            end
        end
    endtask

    initial begin
        @(negedge CLOCK_50);
        test_reset();
        test_identity();
        test_full_scale();
        test_wait_states();
        test_start_while_busy();
        test_reset_mid_job();
        test_full_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
